latency_block_memory: RTL and testbench
=======================================

// Module: latency_block_memory
// PURPOSE
//  Responder end of the cache<->memory block interface: a multi-cycle, block-wide backing store.
//  Accepts one read or write request per transaction (valid/ready handshake) and serves a full cache line after DELAY cycles.
//  Sits below the cache controller; it answers line fills and write-backs.
//  Single outstanding request only; no queuing.
// PARAMETERS
//  BLOCK_SIZE  16    line size in bytes; data ports are BLOCK_SIZE*8 bits
//  NUM_BLOCKS  4096  storage depth in lines (power of two)
//  DELAY       50    cycles from request acceptance to completion (>=1)
// PORTS
//  clk              in   1               rising-edge clock
//  reset            in   1               synchronous, active-high reset
//  is_input_valid   in   1               request present this cycle
//  addr             in   32              line address (byte address >> CLOG2(BLOCK_SIZE))
//  mem_read         in   1               request is a line read
//  mem_write        in   1               request is a line write
//  din              in   BLOCK_SIZE*8    write data (full line)
//  mem_ready        out  1               can accept a request this cycle
//  is_output_valid  out  1               one-cycle completion pulse (reads; writes only under macro)
//  dout             out  BLOCK_SIZE*8    read data, valid while is_output_valid
// BEHAVIOUR
//  - Reset, sampled at the clock edge: state=IDLE, counter=0, is_output_valid=0, dout=0. After the reset edge, mem_ready=1.
//    Storage contents are NOT cleared by reset.
//  - FSM: IDLE, BUSY. mem_ready = (state==IDLE), combinational.
//  - Accept: at edge k with state IDLE, is_input_valid=1 and exactly one of mem_read/mem_write set.
//    On accept: latch index = addr[CLOG2(NUM_BLOCKS)-1:0], op and din; counter<=DELAY-1; state<=BUSY.
//  - Illegal or idle requests are dropped silently; no state change:
//    * mem_read=mem_write=1
//    * mem_read=mem_write=0
//    * any request seen while BUSY (the requester must hold it until mem_ready)
//  - BUSY: counter decrements each edge. At the edge where counter==0, the request completes and state<=IDLE:
//    * read: dout<=mem[index]; is_output_valid=1 for exactly the next cycle.
//    * write: mem[index]<=latched din; is_output_valid stays 0.
//  - Latency: request accepted at edge k completes at edge k+DELAY. mem_ready is low for DELAY cycles.
//    mem_ready rises in the same cycle as the is_output_valid pulse, so a new request can be accepted at edge k+DELAY+1.
//  - Address wrap: upper addr bits above CLOG2(NUM_BLOCKS) are ignored (modulo NUM_BLOCKS).
//  - din/addr changes after acceptance have no effect (latched values are used).
//  - dout holds the last read data between pulses.
//    is_output_valid is 0 on every cycle that is not a completion pulse.
//  - Reset mid-operation (BUSY): the transaction is aborted; a pending write is NOT committed;
//    no is_output_valid pulse; state returns to IDLE.
//  - Read-after-write to the same line: once the write has completed, a read returns the new data.
// CONFIGURATION
//  - DMEM_WRITE_ACK_EN defined: write completion also pulses is_output_valid for one cycle,
//    with dout = the line just written.
//  - DMEM_WRITE_ACK_EN undefined: writes complete silently; the requester detects completion by mem_ready returning to 1.
//  - Read behaviour is identical either way.
// TESTING  (DELAY=4, BLOCK_SIZE=16, NUM_BLOCKS=4096 unless noted)
//  1. Reset: assert reset 2 cycles -> is_output_valid=0, dout=0; mem_ready=1 after the reset edge.
//  2. Write then read line 0x12 (din=128'hDEAD...BEEF), write accepted at edge k:
//     mem_ready=0 for 4 cycles after edge k; the read accepted afterward pulses is_output_valid 4 cycles later with dout=DEAD...BEEF.
//  3. Busy drop: a read of 0x20 is accepted; a write to 0x20 is issued 1 cycle later while BUSY
//     -> the write is ignored; a subsequent read returns the original contents of 0x20.
//  4. Illegal request: mem_read=mem_write=1 with is_input_valid=1 -> mem_ready stays 1, no pulse, memory unchanged.
//  5. Abort: write 0xAA..AA to line 0x5, reset at edge k+2 -> a following read of 0x5 returns the prior data, not 0xAA..AA.
//  6. Wrap: write to addr=0x1005 then read addr=0x0005 -> same data returned.
//     With DMEM_WRITE_ACK_EN, the write also pulses is_output_valid with dout equal to din.

Source files
------------

// File: rtl/latency_block_memory.sv
// latency_block_memory: block-wide backing store answering cache line fills and
// write-backs after a fixed DELAY, one outstanding request at a time.
// Optional feature macro: DMEM_WRITE_ACK_EN -- when defined, write completion also
// pulses is_output_valid with dout carrying the line just written.
module latency_block_memory #(
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned NUM_BLOCKS = 4096,
  parameter int unsigned DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    mem_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout
);

  localparam int unsigned LINE_W = BLOCK_SIZE * 8;
  localparam int unsigned IDX_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

  logic [0:0]        state;
  logic [CNT_W-1:0]  counter;
  logic [IDX_W-1:0]  index;
  logic              op_write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] mem [NUM_BLOCKS];

  logic accept;
  logic complete;
  logic unused_addr_bits;

  assign mem_ready = (state == IDLE);
  // Exactly one of read/write must be set; anything else is dropped silently.
  assign accept    = mem_ready && is_input_valid && (mem_read ^ mem_write);
  assign complete  = (state == BUSY) && (counter == '0);

  // Line index wraps modulo NUM_BLOCKS; the upper address bits are don't-care.
  assign unused_addr_bits = ^addr[31:IDX_W];

  // Control FSM, completion pulse and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= '0;
      is_output_valid <= 1'b0;
      dout            <= '0;
    end else begin
      is_output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            counter <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (counter == '0) begin
            state <= IDLE;
            if (!op_write) begin
              dout            <= mem[index];
              is_output_valid <= 1'b1;
            end else begin
`ifdef DMEM_WRITE_ACK_EN
              dout            <= wdata;
              is_output_valid <= 1'b1;
`endif
            end
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture so later addr/din changes cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      index    <= addr[IDX_W-1:0];
      op_write <= mem_write;
      wdata    <= din;
    end
  end

  // Storage commit; reset aborts a pending write and never clears contents.
  always_ff @(posedge clk) begin
    if (!reset && complete && op_write) begin
      mem[index] <= wdata;
    end
  end

endmodule

// File: tb/tb_latency_block_memory.sv
// Bench for latency_block_memory (DELAY=4): a timestamp-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_latency_block_memory;

  localparam int unsigned DELAY = 4;
  localparam int unsigned NB    = 4096;
  localparam int unsigned BS    = 16;
  localparam int unsigned LW    = BS * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          is_input_valid = 1'b0;
  logic [31:0]   addr = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [LW-1:0] din = '0;
  logic          mem_ready;
  logic          is_output_valid;
  logic [LW-1:0] dout;

  int total = 0;
  int bad   = 0;

  latency_block_memory #(
    .BLOCK_SIZE (BS),
    .NUM_BLOCKS (NB),
    .DELAY      (DELAY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .mem_ready       (mem_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs as seen by the rising edge.
  logic          s_reset = 1'b0, s_valid = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
  logic [31:0]   s_addr = '0;
  logic [LW-1:0] s_din = '0;

  always @(posedge clk) begin
    s_reset <= reset;
    s_valid <= is_input_valid;
    s_rd    <= mem_read;
    s_wr    <= mem_write;
    s_addr  <= addr;
    s_din   <= din;
  end

  // Reference model: a request seen at edge e finishes at edge e+DELAY.
  int            edge_n = 0;
  bit            m_init = 0, m_busy = 0, m_wr = 0;
  int            m_done = 0, m_idx = 0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_mem [int];
  bit            exp_valid = 0, exp_known = 0;
  logic [LW-1:0] exp_dout = '0;

  always @(negedge clk) begin
    edge_n++;
    if (s_reset) begin
      m_init = 1; m_busy = 0; exp_valid = 0; exp_dout = '0; exp_known = 1;
    end else begin
      exp_valid = 0;
      if (m_busy) begin
        if (edge_n == m_done) begin
          m_busy = 0;
          if (m_wr) begin
            m_mem[m_idx] = m_wdata;
`ifdef DMEM_WRITE_ACK_EN
            exp_valid = 1; exp_dout = m_wdata; exp_known = 1;
`endif
          end else begin
            exp_valid = 1;
            if (m_mem.exists(m_idx)) begin
              exp_dout = m_mem[m_idx]; exp_known = 1;
            end else begin
              exp_known = 0;
            end
          end
        end
      end else if (s_valid && (s_rd != s_wr)) begin
        m_busy  = 1;
        m_done  = edge_n + DELAY;
        m_wr    = s_wr;
        m_idx   = int'(s_addr % NB);
        m_wdata = s_din;
      end
    end
    if (m_init) begin
      total++;
      if (mem_ready !== (m_busy ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL model_ready edge=%0d got=%b want=%b", edge_n, mem_ready, !m_busy);
      end
      total++;
      if (is_output_valid !== exp_valid) begin
        bad++;
        $display("FAIL model_valid edge=%0d got=%b want=%b", edge_n, is_output_valid, exp_valid);
      end
      if (exp_known) begin
        total++;
        if (dout !== exp_dout) begin
          bad++;
          $display("FAIL model_dout edge=%0d got=%h want=%h", edge_n, dout, exp_dout);
        end
      end
    end
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One-cycle request, then scramble addr/din to show they are latched.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] d);
    is_input_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; din = d;
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; din = {4{$urandom}};
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!mem_ready && n < budget) begin
      @(negedge clk); n++;
    end
    if (!mem_ready) begin
      bad++; total++;
      $display("FAIL wait_ready timeout got=0 want=1");
    end
  endtask

  task automatic wait_pulse(input int budget, output int n, output logic [LW-1:0] d);
    n = 0;
    while (is_output_valid !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    d = dout;
    if (is_output_valid !== 1'b1) begin
      bad++; total++;
      $display("FAIL wait_pulse timeout got=0 want=1");
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [LW-1:0] d);
    issue(1'b0, 1'b1, a, d);
`ifdef DMEM_WRITE_ACK_EN
    begin
      int n; logic [LW-1:0] got;
      wait_pulse(3 * DELAY, n, got);
      check("write_ack_dout", got, d);
    end
`else
    wait_ready(3 * DELAY);
`endif
  endtask

  task automatic do_read(input logic [31:0] a, output logic [LW-1:0] d);
    int n;
    issue(1'b1, 1'b0, a, '0);
    wait_pulse(3 * DELAY, n, d);
    check("read_latency", LW'(n), LW'(DELAY));
  endtask

  localparam logic [LW-1:0] D12 = 128'hDEADBEEF_01234567_89ABCDEF_0000BEEF;
  localparam logic [LW-1:0] D20 = 128'h20202020_11111111_22222222_33333333;
  localparam logic [LW-1:0] P5  = 128'h55555555_12345678_9ABCDEF0_0F0F0F0F;
  localparam logic [LW-1:0] AA  = {16{8'hAA}};
  localparam logic [LW-1:0] W6  = 128'hC0FFEE00_FEEDFACE_1000_5555_ABCD_0006;

  initial begin
    logic [LW-1:0] got;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", LW'(is_output_valid), '0);
    check("reset_dout", dout, '0);
    check("reset_ready", LW'(mem_ready), LW'(1));
    reset = 1'b0;
    @(negedge clk);

    // Write then read line 0x12; ready low for exactly DELAY cycles.
    issue(1'b0, 1'b1, 32'h12, D12);
    for (int i = 0; i < DELAY; i++) begin
      check("busy_ready_low", LW'(mem_ready), '0);
      @(negedge clk);
    end
    check("ready_back", LW'(mem_ready), LW'(1));
`ifdef DMEM_WRITE_ACK_EN
    check("write_ack_pulse", LW'(is_output_valid), LW'(1));
`else
    check("write_silent", LW'(is_output_valid), '0);
`endif
    do_read(32'h12, got);
    check("raw_0x12", got, D12);
    // Back-to-back read accepted on the edge right after the pulse.
    do_read(32'h12, got);
    check("b2b_0x12", got, D12);

    // Write while busy is dropped.
    do_write(32'h20, D20);
    issue(1'b1, 1'b0, 32'h20, '0);
    issue(1'b0, 1'b1, 32'h20, {16{8'h77}});
    begin
      int n;
      wait_pulse(3 * DELAY, n, got);
    end
    check("busy_read_0x20", got, D20);
    wait_ready(3 * DELAY);
    do_read(32'h20, got);
    check("busy_drop_0x20", got, D20);

    // Illegal requests: both set, neither set.
    is_input_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 32'h12; din = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_ready", LW'(mem_ready), LW'(1));
      check("illegal_valid", LW'(is_output_valid), '0);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    is_input_valid = 1'b0;
    check("none_ready", LW'(mem_ready), LW'(1));
    do_read(32'h12, got);
    check("illegal_mem_kept", got, D12);

    // Reset two edges into a write aborts it.
    do_write(32'h5, P5);
    issue(1'b0, 1'b1, 32'h5, AA);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", LW'(mem_ready), LW'(1));
    check("abort_valid", LW'(is_output_valid), '0);
    check("abort_dout", dout, '0);
    repeat (DELAY + 2) @(negedge clk);
    do_read(32'h5, got);
    check("abort_0x5", got, P5);

    // Address wrap modulo NUM_BLOCKS.
    do_write(32'h1005, W6);
    do_read(32'h0005, got);
    check("wrap_0x5", got, W6);
    do_read(32'h0012 + 32'h3000, got);
    check("wrap_0x3012", got, D12);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
